// File: rtl/inv_shift_rows_stage_if.sv
// Valid/ready stream carrying one AES state block plus its side-band round tag.
// The producer uses the master modport and the consumer uses the slave modport.
interface inv_shift_rows_stage_if #(
  parameter int unsigned DATA_LEN = 128,
  parameter int unsigned TAG_LEN  = 4
) ();

  logic                valid;
  logic                ready;
  logic [DATA_LEN-1:0] data;
  logic [TAG_LEN-1:0]  tag;

  modport master (
    output valid,
    output data,
    output tag,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  tag,
    output ready
  );

endinterface

// File: rtl/inv_shift_rows_stage.sv
// AES (Inv)ShiftRows pipeline stage with a two-entry skid buffer and a round tag.
// Defining SHIFT_ROWS_FWD_EN adds a fwd_mode port that selects the forward ShiftRows per block.
module inv_shift_rows_stage #(
  parameter int unsigned DATA_LEN = 128,
  parameter int unsigned TAG_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SHIFT_ROWS_FWD_EN
  input  logic                    fwd_mode,
`endif
  inv_shift_rows_stage_if.slave   in_if,
  inv_shift_rows_stage_if.master  out_if
);

  localparam int unsigned NUM_BYTES = DATA_LEN / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                state_q, state_d;
  logic [DATA_LEN-1:0] main_data_q, main_data_d;
  logic [TAG_LEN-1:0]  main_tag_q, main_tag_d;
  logic [DATA_LEN-1:0] skid_data_q, skid_data_d;
  logic [TAG_LEN-1:0]  skid_tag_q, skid_tag_d;
  logic                in_ready_q, in_ready_d;

  logic [DATA_LEN-1:0] xf_data;
  logic                in_fire;
  logic                out_fire;
  logic                out_valid;

  // Byte 4c+r of the state is row r, column c; row r rotates by r byte positions.
  function automatic logic [DATA_LEN-1:0] shift_rows(input logic [DATA_LEN-1:0] s,
                                                     input logic                fwd);
    logic [DATA_LEN-1:0] res;
    int unsigned         src;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (fwd) begin
          src = 4 * ((c + r) % 4) + r;
        end else begin
          src = 4 * ((c + 4 - r) % 4) + r;
        end
        res[(NUM_BYTES-1-(4*c+r))*8 +: 8] = s[(NUM_BYTES-1-src)*8 +: 8];
      end
    end
    return res;
  endfunction

  always_comb begin
`ifdef SHIFT_ROWS_FWD_EN
    xf_data = shift_rows(in_if.data, fwd_mode);
`else
    xf_data = shift_rows(in_if.data, 1'b0);
`endif
  end

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_if.valid & in_ready_q;
  assign out_fire  = out_valid & out_if.ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = xf_data;
          main_tag_d  = in_if.tag;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = xf_data;
          main_tag_d  = in_if.tag;
        end else if (in_fire) begin
          skid_data_d = xf_data;
          skid_tag_d  = in_if.tag;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only event is draining skid into main.
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_tag_d  = skid_tag_q;
          state_d     = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data_q;
  assign out_if.tag   = main_tag_q;

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Directed and scoreboarded bench for inv_shift_rows_stage.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_inv_shift_rows_stage;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  inv_shift_rows_stage_if #(.DATA_LEN(128), .TAG_LEN(4)) in_if ();
  inv_shift_rows_stage_if #(.DATA_LEN(128), .TAG_LEN(4)) out_if ();

`ifdef SHIFT_ROWS_FWD_EN
  logic fwd_mode;
`endif

  inv_shift_rows_stage #(.DATA_LEN(128), .TAG_LEN(4)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef SHIFT_ROWS_FWD_EN
    .fwd_mode (fwd_mode),
`endif
    .in_if    (in_if),
    .out_if   (out_if)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_data[$];
  logic [3:0]   exp_tag[$];
  bit           pend;
  bit           prev_stall;
  logic [127:0] prev_data;
  logic [3:0]   prev_tag;
  int           n_out;
  logic [3:0]   blk_cnt;
  bit           blk_fwd;
  bit           alt_fwd;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Reference byte permutation taken straight from the column listing.
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input bit fwd);
    int unsigned  inv_map[16];
    int unsigned  fwd_map[16];
    int unsigned  src;
    logic [127:0] o;
    inv_map = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    fwd_map = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = fwd ? fwd_map[i] : inv_map[i];
      o[(15-i)*8 +: 8] = s[(15-src)*8 +: 8];
    end
    return o;
  endfunction

  task automatic clear_model();
    exp_data.delete();
    exp_tag.delete();
    pend       = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One cycle: check outputs, drive inputs, predict fires, advance to the next falling edge.
  task automatic step(input bit offer, input bit rdy);
    bit in_fire;
    bit out_fire;
    if (out_if.valid) begin
      if (exp_data.size() == 0) begin
        check("out_while_empty", 128'(out_if.valid), 128'(0));
      end else begin
        check("out_data", out_if.data, exp_data[0]);
        check("out_tag", 128'(out_if.tag), 128'(exp_tag[0]));
      end
      if (prev_stall) begin
        check("hold_data", out_if.data, prev_data);
        check("hold_tag", 128'(out_if.tag), 128'(prev_tag));
      end
    end else if (prev_stall) begin
      check("hold_valid", 128'(out_if.valid), 128'(1));
    end

    if (!pend) begin
      if (offer) begin
        in_if.valid = 1'b1;
        in_if.data  = {$urandom, $urandom, $urandom, $urandom};
        in_if.tag   = blk_cnt;
        blk_cnt     = blk_cnt + 4'd1;
        if (alt_fwd) blk_fwd = ~blk_fwd;
`ifdef SHIFT_ROWS_FWD_EN
        fwd_mode = blk_fwd;
`endif
      end else begin
        in_if.valid = 1'b0;
      end
    end
    out_if.ready = rdy;

    in_fire  = in_if.valid && in_if.ready;
    out_fire = out_if.valid && rdy;
    if (out_fire && exp_data.size() > 0) begin
      void'(exp_data.pop_front());
      void'(exp_tag.pop_front());
      n_out++;
    end
    if (in_fire) begin
      exp_data.push_back(ref_sr(in_if.data, blk_fwd));
      exp_tag.push_back(in_if.tag);
    end
    pend       = in_if.valid && !in_if.ready;
    prev_stall = out_if.valid && !rdy;
    prev_data  = out_if.data;
    prev_tag   = out_if.tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] vec_in;
    vec_in       = 128'h000102030405060708090a0b0c0d0e0f;
    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.tag    = '0;
    out_if.ready = 1'b0;
    blk_cnt      = 4'd0;
    blk_fwd      = 1'b0;
    alt_fwd      = 1'b0;
    n_out        = 0;
`ifdef SHIFT_ROWS_FWD_EN
    fwd_mode     = 1'b0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_valid", 128'(out_if.valid), 128'(0));
    check("rst_data", out_if.data, 128'(0));
    check("rst_tag", 128'(out_if.tag), 128'(0));
    check("rst_in_ready", 128'(in_if.ready), 128'(1));
    reset = 1'b0;

    // Single known block.
    in_if.valid  = 1'b1;
    in_if.data   = vec_in;
    in_if.tag    = 4'd3;
    out_if.ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_if.valid = 1'b0;
    check("single_valid", 128'(out_if.valid), 128'(1));
    check("single_data", out_if.data, 128'h000d0a0704010e0b0805020f0c090603);
    check("single_tag", 128'(out_if.tag), 128'(3));
    @(posedge clk);
    @(negedge clk);
    check("single_valid_gone", 128'(out_if.valid), 128'(0));

    // Back-to-back stream of 16 blocks.
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      check("stream_in_ready", 128'(in_if.ready), 128'(1));
      step(1'b1, 1'b1);
    end
    repeat (2) step(1'b0, 1'b1);
    check("stream_count", 128'(n_out), 128'(16));
    check("stream_left", 128'(exp_data.size()), 128'(0));

    // Backpressure: two blocks fit, the third waits.
    n_out = 0;
    step(1'b1, 1'b0);
    check("bp_ready_after_1", 128'(in_if.ready), 128'(1));
    step(1'b1, 1'b0);
    check("bp_ready_after_2", 128'(in_if.ready), 128'(0));
    step(1'b1, 1'b0);
    check("bp_third_pending", 128'(pend), 128'(1));
    repeat (3) step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("bp_count", 128'(n_out), 128'(3));
    check("bp_left", 128'(exp_data.size()), 128'(0));
    check("bp_pending_done", 128'(pend), 128'(0));

    // Random valid/ready traffic.
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20 && (pend || exp_data.size() != 0); i++) step(1'b0, 1'b1);
    check("rand_left", 128'(exp_data.size()), 128'(0));
    check("rand_pending", 128'(pend), 128'(0));
    check("rand_some_out", 128'(n_out > 2000), 128'(1));

    // Reset while full, with handshakes attempted during the reset cycle.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("full_in_ready", 128'(in_if.ready), 128'(0));
    in_if.valid  = 1'b1;
    in_if.data   = vec_in;
    out_if.ready = 1'b1;
    reset        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    in_if.valid = 1'b0;
    clear_model();
    check("rst_full_valid", 128'(out_if.valid), 128'(0));
    check("rst_full_data", out_if.data, 128'(0));
    check("rst_full_in_ready", 128'(in_if.ready), 128'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      check("post_rst_valid", 128'(out_if.valid), 128'(0));
    end

`ifdef SHIFT_ROWS_FWD_EN
    in_if.valid  = 1'b1;
    in_if.data   = vec_in;
    in_if.tag    = 4'd5;
    fwd_mode     = 1'b1;
    out_if.ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_if.valid = 1'b0;
    check("fwd_data", out_if.data, 128'h00050a0f04090e03080d02070c01060b);
    check("fwd_tag", 128'(out_if.tag), 128'(5));
    @(posedge clk);
    @(negedge clk);
    clear_model();
    n_out   = 0;
    alt_fwd = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20 && (pend || exp_data.size() != 0); i++) step(1'b0, 1'b1);
    check("fwd_alt_count", 128'(n_out), 128'(16));
    alt_fwd = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stage.md
# inv_shift_rows_stage

Inverse ShiftRows stage for the AES decryption datapath: cyclically rotates each row of the 4x4 byte state right by its row index (row r by r bytes). It sits between the AddRoundKey/InvMixColumns stage and InvSubBytes. It has valid/ready handshakes on both sides and a two-entry skid buffer, so it sustains one block per cycle under arbitrary downstream backpressure. A side-band round tag travels with each block.

## Interface
- DATA_LEN, 128, state width in bits; only 128 is supported.
- TAG_LEN, 4, width of the side-band round tag carried alongside the data.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  stage can accept a block this cycle.
- in_data  input  DATA_LEN  input state; byte i = in_data[(15-i)*8 +: 8], column-major (byte 4c+r = row r, col c).
- in_tag  input  TAG_LEN  round tag for in_data.
- out_valid  output  1  out_data/out_tag hold a valid block.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_LEN  transformed state, same byte packing as in_data.
- out_tag  output  TAG_LEN  tag of the block on out_data.
- fwd_mode  input  1  present only with SHIFT_ROWS_FWD_EN; see Configuration.

## Operation
- Transform (inverse): out[4c+r] = in[4*((c-r+4) mod 4)+r].
  - Columns out: {S0,S13,S10,S7}, {S4,S1,S14,S11}, {S8,S5,S2,S15}, {S12,S9,S6,S3}.
- The transform is applied combinationally on the input side. Both buffer entries store already-transformed data plus the tag.
- Entries: main register (drives outputs) and skid register.
- Occupancy states: EMPTY (neither valid), ONE (main valid), FULL (main and skid valid).
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready is registered and equals !skid_valid.
- Transitions:
  - EMPTY, in_fire: load main -> ONE.
  - ONE, in_fire & out_fire: reload main -> ONE.
  - ONE, in_fire & !out_fire: load skid -> FULL.
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL, out_fire: skid moves to main -> ONE. No in_fire is possible, because in_ready=0.
  - Otherwise hold.
- out_data/out_tag change only on out_fire or when loading from EMPTY. They stay stable while out_valid & !out_ready.
- Blocks leave in acceptance order; no block is dropped or duplicated.
- in_valid while in_ready=0: ignored; upstream must hold its block.

## Timing
- Latency: a block accepted at edge N appears on out_valid/out_data after edge N (visible in cycle N+1) when the stage is EMPTY, or when ONE with out_fire in the same cycle.
- Throughput: 1 block/cycle while out_ready=1.
- Backpressure: in_ready falls one cycle after the first cycle out_ready=0 with a block stalled. At most 2 blocks are held.
- Reset (sampled high at an edge): out_valid=0, out_data=0, out_tag=0, skid cleared, in_ready=1 after the edge.
  - Handshakes during the reset cycle are discarded.
  - Reset mid-stream drops all held blocks.
- Simultaneous in_fire and out_fire in ONE: the output updates to the new block the next cycle with no bubble.

## Configuration
- SHIFT_ROWS_FWD_EN defined:
  - Adds the fwd_mode port, sampled with in_data on in_fire and stored per entry.
  - fwd_mode=1 applies forward ShiftRows: out[4c+r] = in[4*((c+r) mod 4)+r]. fwd_mode=0 applies the inverse.
  - This lets a shared encrypt/decrypt core use one instance.
- Undefined: no fwd_mode port; the stage is inverse-only.

## Test plan
- Reset, then a single block in_data=000102030405060708090a0b0c0d0e0f, tag=3, out_ready=1:
  - out_data=000d0a0704010e0b0805020f0c090603 and out_tag=3 one cycle after accept.
  - out_valid=1 for exactly one cycle.
- Streaming 16 blocks back to back with out_ready=1:
  - in_ready stays 1; 16 outputs in order, one per cycle, each matching the reference model.
- Backpressure: hold out_ready=0 while sending 3 blocks:
  - first 2 accepted; in_ready=0 on the third.
  - out_data stable at block 1. After releasing out_ready, blocks 1, 2, 3 emerge in order with no loss.
- Random in_valid/out_ready (10k cycles): scoreboard shows zero drops/duplicates. out_data/out_tag never change while out_valid & !out_ready.
- Reset asserted while FULL: the next cycle shows out_valid=0, out_data=0, in_ready=1; no stale block appears afterwards.
- With SHIFT_ROWS_FWD_EN, fwd_mode=1, input 000102...0f: out_data=00050a0f04090e03080d02070c01060b. Alternating fwd_mode per block gives the correct per-block transform.
